vu_level_driver: RTL and testbench



---
 rtl/vu_level_driver.sv | 182 ++++++++++++++++++
 tb/tb_vu_level_driver.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/vu_level_driver.sv
// VU meter test top: 8N1 UART byte in, clamped bar level out as a WS2812 frame.
// Green/yellow/red bar segments, one frame per received level.
module vu_level_driver #(
    parameter int         CLKS_PER_BIT = 416,
    parameter int         NUM_LEDS     = 20,
    parameter int         GREEN_LEDS   = 12,
    parameter int         YELLOW_LEDS  = 4,
    parameter logic [7:0] BRIGHT       = 8'h10,
    parameter int         T_BIT        = 60,
    parameter int         T0H          = 19,
    parameter int         T1H          = 38,
    parameter int         T_RST        = 2400
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_rx,
    output logic o_npxl_data,
    output logic o_rdy
);

    localparam int LVL_W = $clog2(NUM_LEDS + 1);
    localparam int UC_W  = $clog2(CLKS_PER_BIT);
    localparam int DC_W  = $clog2((T_RST > T_BIT) ? T_RST : T_BIT);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {DRV_IDLE, DRV_SEND, DRV_LATCH} drv_state_t;

    logic             rx_meta, rx_sync;
    rx_state_t        rx_state;
    logic [UC_W-1:0]  rx_cnt;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             rx_strobe;

    drv_state_t       drv_state;
    logic [DC_W-1:0]  drv_cnt;
    logic [LVL_W-1:0] level, frame_level, led_idx, clamped;
    logic [4:0]       bit_pos;
    logic             pending;
    logic [23:0]      cur_colour;
    logic             cur_bit, next_high, frame_start;

    // NOTE: sequential state uses non-blocking assignments only; blocking here would
    // make the second flop of the synchroniser collapse into the first.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_state  <= RX_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            rx_strobe <= 1'b0;
        end else begin
            rx_strobe <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (!rx_sync) rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt == UC_W'(CLKS_PER_BIT / 2 - 1)) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == UC_W'(CLKS_PER_BIT - 1)) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 1'b1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == UC_W'(CLKS_PER_BIT - 1)) begin
                        rx_cnt    <= '0;
                        rx_strobe <= rx_sync;  // low stop bit drops the byte
                        rx_state  <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    function automatic logic [23:0] led_colour(input logic [LVL_W-1:0] idx,
                                               input logic [LVL_W-1:0] lvl);
        if (idx >= lvl)                                 return 24'h000000;
        else if (int'(idx) < GREEN_LEDS)                return {BRIGHT, 8'h00, 8'h00};
        else if (int'(idx) < GREEN_LEDS + YELLOW_LEDS)  return {BRIGHT, BRIGHT, 8'h00};
        else                                            return {8'h00, BRIGHT, 8'h00};
    endfunction

    always_comb begin
        clamped     = (rx_shift > 8'(NUM_LEDS)) ? LVL_W'(NUM_LEDS) : rx_shift[LVL_W-1:0];
        cur_colour  = led_colour(led_idx, frame_level);
        cur_bit     = cur_colour[bit_pos];
        next_high   = (int'(drv_cnt) + 1) < (cur_bit ? T1H : T0H);
        // A pending level starts a frame from IDLE or straight out of the latch gap.
        frame_start = pending && ((drv_state == DRV_IDLE) ||
                      (drv_state == DRV_LATCH && drv_cnt == DC_W'(T_RST - 1)));
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            drv_state   <= DRV_IDLE;
            drv_cnt     <= '0;
            level       <= '0;
            frame_level <= '0;
            led_idx     <= '0;
            bit_pos     <= '0;
            pending     <= 1'b0;
            o_npxl_data <= 1'b0;
            o_rdy       <= 1'b1;
        end else begin
            if (rx_strobe) level <= clamped;
            if (rx_strobe)        pending <= 1'b1;
            else if (frame_start) pending <= 1'b0;

            if (frame_start) begin
                drv_state   <= DRV_SEND;
                frame_level <= level;
                led_idx     <= '0;
                bit_pos     <= 5'd23;
                drv_cnt     <= '0;
                o_npxl_data <= 1'b1;
                o_rdy       <= 1'b0;
            end else begin
                case (drv_state)
                    DRV_IDLE: o_rdy <= 1'b1;
                    DRV_SEND: begin
                        if (drv_cnt == DC_W'(T_BIT - 1)) begin
                            drv_cnt <= '0;
                            if (bit_pos != 5'd0) begin
                                bit_pos     <= bit_pos - 1'b1;
                                o_npxl_data <= 1'b1;
                            end else if (led_idx == LVL_W'(NUM_LEDS - 1)) begin
                                drv_state   <= DRV_LATCH;
                                o_npxl_data <= 1'b0;
                            end else begin
                                led_idx     <= led_idx + 1'b1;
                                bit_pos     <= 5'd23;
                                o_npxl_data <= 1'b1;
                            end
                        end else begin
                            drv_cnt     <= drv_cnt + 1'b1;
                            o_npxl_data <= next_high;
                        end
                    end
                    DRV_LATCH: begin
                        o_npxl_data <= 1'b0;
                        if (drv_cnt == DC_W'(T_RST - 1)) begin
                            drv_cnt   <= '0;
                            drv_state <= DRV_IDLE;
                            o_rdy     <= 1'b1;
                        end else begin
                            drv_cnt <= drv_cnt + 1'b1;
                        end
                    end
                    default: drv_state <= DRV_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vu_level_driver.sv
// Directed bench for vu_level_driver: decodes each WS2812 frame from the pin and
// compares it with hand-derived bar colours; shortened timing parameters.
module tb_vu_level_driver;

    localparam int CPB    = 16;
    localparam int NLEDS  = 20;
    localparam int TBIT   = 10;
    localparam int T0     = 3;
    localparam int T1     = 6;
    localparam int TRST   = 40;
    localparam int FRAME  = NLEDS * 24 * TBIT + TRST;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;
    logic i_rx  = 1'b1;
    logic o_npxl_data, o_rdy;

    int checks = 0;
    int errors = 0;

    vu_level_driver #(
        .CLKS_PER_BIT(CPB), .NUM_LEDS(NLEDS), .GREEN_LEDS(12), .YELLOW_LEDS(4),
        .BRIGHT(8'h10), .T_BIT(TBIT), .T0H(T0), .T1H(T1), .T_RST(TRST)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_rx(i_rx),
        .o_npxl_data(o_npxl_data), .o_rdy(o_rdy)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #(10 * 200000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [479:0] obs, input logic [479:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hand-derived GRB words: green 10_00_00, yellow 10_10_00, red 00_10_00.
    function automatic logic [479:0] exp_frame(input int lit);
        logic [479:0] f;
        logic [23:0]  c;
        f = '0;
        for (int n = 0; n < NLEDS; n++) begin
            if (n >= lit)    c = 24'h000000;
            else if (n < 12) c = 24'h100000;
            else if (n < 16) c = 24'h101000;
            else             c = 24'h001000;
            f[479 - 24 * n -: 24] = c;
        end
        return f;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge i_clk) i_rx = 1'b0;
        repeat (CPB) @(negedge i_clk);
        for (int i = 0; i < 8; i++) begin
            i_rx = b[i];
            repeat (CPB) @(negedge i_clk);
        end
        i_rx = stop;
        repeat (CPB) @(negedge i_clk);
        i_rx = 1'b1;
    endtask

    task automatic wait_rise(input int max, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge i_clk);
            if (o_npxl_data === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Entered on the negedge where the first high sample of bit 0 was seen.
    task automatic capture_frame(output logic [479:0] bits, output int bad, output int rdy_low);
        int  h;
        logic s, seen_low;
        bad = 0;
        rdy_low = 0;
        bits = '0;
        for (int b = 0; b < NLEDS * 24; b++) begin
            h = 0;
            seen_low = 1'b0;
            for (int k = 0; k < TBIT; k++) begin
                if (!(b == 0 && k == 0)) @(negedge i_clk);
                s = o_npxl_data;
                if (o_rdy === 1'b0) rdy_low++;
                if (k == 0 && s !== 1'b1) bad++;
                if (s === 1'b1) begin
                    if (seen_low) bad++;
                    h++;
                end else begin
                    seen_low = 1'b1;
                end
            end
            if (h != T0 && h != T1) bad++;
            bits[479 - b] = (h == T1);
        end
        for (int k = 0; k < TRST; k++) begin
            @(negedge i_clk);
            if (o_npxl_data !== 1'b0) bad++;
            if (o_rdy === 1'b0) rdy_low++;
        end
    endtask

    task automatic check_frame(input string tag, input int lit);
        logic [479:0] bits;
        int bad, rdy_low;
        capture_frame(bits, bad, rdy_low);
        check({tag, " bits"}, bits, exp_frame(lit));
        check({tag, " bit timing errors"}, 480'(bad), 480'(0));
        check({tag, " rdy low clocks"}, 480'(rdy_low), 480'(FRAME));
    endtask

    task automatic do_frame(input string tag, input logic [7:0] b, input int lit);
        logic ok;
        fork
            send_byte(b, 1'b1);
        join_none
        wait_rise(400, ok);
        check({tag, " frame start"}, 480'(ok), 480'(1));
        if (ok) begin
            check_frame(tag, lit);
            @(negedge i_clk);
            check({tag, " rdy after latch"}, 480'(o_rdy), 480'(1));
            check({tag, " data after latch"}, 480'(o_npxl_data), 480'(0));
        end
    endtask

    task automatic watch_idle(input int n, output int viol);
        viol = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge i_clk);
            if (o_npxl_data !== 1'b0 || o_rdy !== 1'b1) viol++;
        end
    endtask

    initial begin
        int   viol;
        logic ok;

        repeat (3) @(negedge i_clk);
        check("reset data", 480'(o_npxl_data), 480'(0));
        check("reset rdy", 480'(o_rdy), 480'(1));
        i_rst = 1'b0;
        watch_idle(300, viol);
        check("no frame after reset", 480'(viol), 480'(0));

        do_frame("byte 3", 8'd3, 3);
        do_frame("byte 11", 8'd11, 11);
        do_frame("byte 20", 8'd20, 20);
        do_frame("byte 0", 8'd0, 0);
        do_frame("byte 25 clamp", 8'd25, 20);

        fork
            send_byte(8'hA5, 1'b0);
        join_none
        watch_idle(600, viol);
        check("stop bit low ignored", 480'(viol), 480'(0));

        // Two bytes land mid-frame: frame 1 keeps level 3, frame 2 shows only 15.
        fork
            send_byte(8'd3, 1'b1);
        join_none
        wait_rise(400, ok);
        check("overlap frame start", 480'(ok), 480'(1));
        if (ok) begin
            fork
                begin
                    repeat (200) @(negedge i_clk);
                    send_byte(8'd7, 1'b1);
                    send_byte(8'd15, 1'b1);
                end
            join_none
            check_frame("overlap first", 3);
            @(negedge i_clk);
            check("overlap second starts at once", 480'(o_npxl_data), 480'(1));
            check("overlap rdy stays low", 480'(o_rdy), 480'(0));
            if (o_npxl_data === 1'b1) begin
                check_frame("overlap second", 15);
                @(negedge i_clk);
                check("overlap rdy after", 480'(o_rdy), 480'(1));
            end
        end

        fork
            send_byte(8'd20, 1'b1);
        join_none
        wait_rise(400, ok);
        check("reset test frame start", 480'(ok), 480'(1));
        repeat (100) @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        check("mid-frame reset data", 480'(o_npxl_data), 480'(0));
        check("mid-frame reset rdy", 480'(o_rdy), 480'(1));
        @(negedge i_clk);
        i_rst = 1'b0;
        watch_idle(FRAME + 200, viol);
        check("no frame after mid-frame reset", 480'(viol), 480'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
